fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction fetch queue:
//   fetch_state_e - fetch controller states (RUN, WAIT, DRAIN)
//   PC_INC        - fetch address increment per accepted request
//   NOP_INSTR     - instruction word presented while the queue is empty
//   fq_entry_t    - one queue entry {pc, instr}
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// In-order storage for fetched {pc, instr} entries.
// Parameters:
//   DEPTH  - number of entries (2, 4 or 8)
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   push, push_data - write one entry at the tail
//   pop             - drop the head entry (ignored when empty)
//   flush           - discard every entry; wins over push and pop
//   head            - current head entry (undefined while empty)
//   full, empty     - occupancy flags
//   count           - current occupancy
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end: issues word-aligned fetch requests (at most one
// outstanding), registers each response for one cycle and queues it in order
// toward the decode/execute datapath. Redirects flush the queue and restart
// fetch at the new target; a response already in flight is discarded.
// Parameters:
//   DEPTH     - queue entries (2, 4 or 8)
//   RESET_PC  - first fetch address after reset
// Ports:
//   clk, reset                      - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     - taken branch/jump target
//   imem_req_valid/addr/ready       - fetch request handshake
//   imem_rsp_valid, imem_rsp_data   - one-cycle response pulse
//   out_valid/ready, out_instr/pc   - queue head toward the datapath
//   busy                            - request in flight or entries queued
//   stall_cnt                       - (FETCH_QUEUE_PERF_EN only) cycles the
//                                     datapath was ready but starved
// Optional feature macro: FETCH_QUEUE_PERF_EN
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 2;

  fetch_state_e          state;
  logic [31:0]           fetch_pc;
  logic [31:0]           req_pc_p0;
  logic                  vld_p1;
  fq_entry_t             rsp_p1;
  fq_entry_t             fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_push;
  logic [CW-1:0]         inflight;
  logic                  req_fire;
  logic                  rsp_take;

  // Entries already claimed: queued, parked in the response register, or
  // still being fetched. A new request is only issued if it has a free slot.
  assign inflight = CW'(fifo_count) + CW'(vld_p1) + CW'(state == WAIT);

  // Gating with reset keeps the request low during reset even though the
  // controller sits in RUN.
  assign imem_req_valid = reset && (state == RUN) && !redirect_valid &&
                          (inflight < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response coinciding with a redirect belongs to the old path.
  assign rsp_take  = imem_rsp_valid && (state == WAIT) && !redirect_valid;
  assign fifo_push = vld_p1 && !redirect_valid && (!fifo_full || out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        RUN:     if (req_fire) state <= WAIT;
        // A response arriving together with a redirect is simply dropped;
        // there is nothing left to drain.
        WAIT:    if (imem_rsp_valid) state <= RUN;
                 else if (redirect_valid) state <= DRAIN;
        // A further redirect only retargets fetch; the stale response still
        // ends the drain.
        DRAIN:   if (imem_rsp_valid) state <= RUN;
        default: state <= RUN;
      endcase
      if (redirect_valid) fetch_pc <= redirect_pc & ~32'd3;
      else if (req_fire)  fetch_pc <= fetch_pc + PC_INC;
      vld_p1 <= rsp_take;
    end
  end

  // ---- stage p0: address of the outstanding request ----
  // ---- stage p1: registered response, pushed into the queue next cycle ----
  always_ff @(posedge clk) begin
    if (req_fire) req_pc_p0 <= fetch_pc;
    if (rsp_take) begin
      rsp_p1.pc    <= req_pc_p0;
      rsp_p1.instr <= imem_rsp_data;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rsp_p1),
    .pop       (out_ready),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? 32'h0000_0000 : fifo_head.pc;
  assign out_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign busy      = (state != RUN) || vld_p1 || !fifo_empty;

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if (redirect_valid) begin
      stall_cnt <= 16'h0000;
    end else if (out_ready && !out_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the fetch stream.
// A second instance with RESET_PC = 32'hFFFF_FFF8 shares the inputs.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_ready;
  logic        imem_req_valid, out_valid, busy;
  logic [31:0] imem_req_addr, out_instr, out_pc;
  logic        req_valid2, out_valid2, busy2;
  logic [31:0] req_addr2, out_instr2, out_pc2;
`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
`ifdef FETCH_QUEUE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .busy(busy2)
`ifdef FETCH_QUEUE_PERF_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] idata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Reference model: the expected fetch stream since the last redirect.
  typedef struct { logic [31:0] pc; bit done; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  bit          pend, pend_live, stale_rsp, prev_redir;
  int          pend_cnt, lat, cyc_n, first_ov, ov_cnt;
  logic [31:0] pend_addr;
  logic [31:0] acc_log[$], acc2_log[$], pop_log[$];

  task automatic clear_model(input logic [31:0] rpc);
    exp_q.delete();
    pend = 0; pend_live = 0; prev_redir = 0; stale_rsp = 0;
    model_pc = rpc;
    cyc_n = 0; first_ov = -1; ov_cnt = 0;
    acc_log.delete(); acc2_log.delete(); pop_log.delete();
  endtask

  // One clock cycle: inputs already set by the caller; memory response driven
  // here; outputs sampled 1 time unit after the drive, model advanced after
  // the rising edge.
  task automatic cycle();
    bit acc, acc2, popd, rsp_now, redir;
    logic [31:0] r_pc, a_addr;
    rsp_now = pend && (pend_cnt == 0);
    imem_rsp_valid = rsp_now || stale_rsp;
    imem_rsp_data  = rsp_now ? idata(pend_addr) : 32'hDEAD_BEEF;
    #1;
    redir = redirect_valid;
    r_pc  = redirect_pc;
    check("req_valid", 32'(imem_req_valid), 32'(!pend && !redir && (exp_q.size() < DEPTH)));
    if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
    check("busy", 32'(busy), 32'(pend || (exp_q.size() != 0)));
    if (prev_redir) check("ov_after_redirect", 32'(out_valid), 32'd0);
    acc    = imem_req_valid && imem_req_ready;
    a_addr = imem_req_addr;
    acc2   = req_valid2 && imem_req_ready;
    popd   = out_valid && out_ready;
    if (out_valid) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = cyc_n;
    end
    if (popd) begin
      pop_log.push_back(out_pc);
      if (exp_q.size() == 0) check("pop_unexpected", 32'(out_valid), 32'd0);
      else begin
        check("pop_pc", out_pc, exp_q[0].pc);
        check("pop_instr", out_instr, idata(exp_q[0].pc));
        check("pop_entry_fetched", 32'(exp_q[0].done), 32'd1);
      end
    end
    if (acc)  acc_log.push_back(a_addr);
    if (acc2) acc2_log.push_back(req_addr2);
    @(posedge clk);
    #1;
    if (redir) begin
      exp_q.delete();
      pend_live = 0;
      model_pc  = r_pc & ~32'd3;
    end else begin
      if (rsp_now && pend_live && (exp_q.size() != 0)) exp_q[exp_q.size()-1].done = 1;
      if (popd && (exp_q.size() != 0)) void'(exp_q.pop_front());
    end
    if (rsp_now) pend = 0;
    else if (pend) pend_cnt--;
    if (acc) begin
      pend = 1; pend_live = 1; pend_addr = a_addr; pend_cnt = lat - 1;
      exp_q.push_back('{pc: model_pc, done: 1'b0});
      model_pc = model_pc + 32'd4;
    end
    prev_redir = redir;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; out_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    lat = 1;
    clear_model(32'h0);
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst2_req_valid", 32'(req_valid2), 32'd0);
    check("rst2_out", {out_pc2[15:0], out_instr2[15:0]}, 32'd0);
    check("rst2_flags", 32'({out_valid2, busy2}), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
    check("rst_stall_cnt", 32'({stall_cnt, stall_cnt2}), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic streaming from reset
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (12) cycle();
    check("stream_first_ov_cycle", 32'(first_ov), 32'd3);
    check("stream_pops", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("stream_pc", pop_log[i], 32'(i * 4));
    check("wrap_reqs", 32'(acc2_log.size() >= 3), 32'd1);
    if (acc2_log.size() >= 3) begin
      check("wrap_req0", acc2_log[0], 32'hFFFF_FFF8);
      check("wrap_req1", acc2_log[1], 32'hFFFF_FFFC);
      check("wrap_req2", acc2_log[2], 32'h0000_0000);
    end

    // Fill the queue with the consumer stalled
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (20) cycle();
    check("full_req_count", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4)
      for (int i = 0; i < 4; i++) check("full_req_addr", acc_log[i], 32'(i * 4));
    check("full_req_held_low", 32'(imem_req_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc_log.size() < 5; i++) cycle();
    check("resume_req_seen", 32'(acc_log.size()), 32'd5);
    if (acc_log.size() == 5) check("resume_addr", acc_log[4], 32'd16);

    // Redirect while a request is in flight
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0; lat = 3;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && pop_log.size() < 1; i++) cycle();
    check("redir_pop_seen", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() >= 1) check("redir_first_pc", pop_log[0], 32'h0000_0100);
    check("redir_req_count", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) check("redir_req_addr", acc_log[1], 32'h0000_0100);

    // Reset during an outstanding request, then a stale response
    do_reset();
    imem_req_ready = 1'b1; lat = 3;
    cycle();
    reset = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model(32'h0);
    imem_req_ready = 1'b0; out_ready = 1'b1;
    stale_rsp = 1'b1;
    cycle();
    stale_rsp = 1'b0;
    repeat (4) cycle();
    check("stale_out_valid_cycles", 32'(ov_cnt), 32'd0);
    check("stale_next_addr", imem_req_addr, 32'h0000_0000);
    imem_req_ready = 1'b1;
    cycle();
    check("stale_req_accepted", 32'(acc_log.size()), 32'd1);

`ifdef FETCH_QUEUE_PERF_EN
    // Stall counter
    do_reset();
    imem_req_ready = 1'b0; out_ready = 1'b1;
    repeat (5) cycle();
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    redirect_valid = 1'b0;
    check("stall_cnt_clear", 32'(stall_cnt), 32'd0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      out_ready      = ($urandom_range(2) != 0);
      lat            = $urandom_range(3, 1);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom();
      stale_rsp      = !pend && ($urandom_range(9) == 0);
      cycle();
    end
    redirect_valid = 1'b0;
    stale_rsp = 1'b0;
    check("rand_pops_made", 32'(pop_log.size() > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
